// File: rtl/sprite_scroller_if.sv
// Sprite scroller control/status bundle: game controls in, sprite position and status out.
interface sprite_scroller_if;
  logic       enable;
  logic       pause;
  logic       hit;
  logic [8:0] xoffset;
  logic [7:0] yoffset;
  logic       wrap_pulse;
  logic [3:0] level;
  logic       running;

  modport master (output enable, pause, hit,
                  input  xoffset, yoffset, wrap_pulse, level, running);
  modport slave  (input  enable, pause, hit,
                  output xoffset, yoffset, wrap_pulse, level, running);
endinterface

// File: rtl/sprite_scroller.sv
// Sprite scroller: steps a sprite leftwards once per (cur+1) cycles, wraps or respawns on hit.
// Optional speed ramp on each wrap enabled by macro SPRITE_SCROLLER_RAMP_EN.
module sprite_scroller #(
  parameter int X_START    = 160,
  parameter int Y_POS      = 120,
  parameter int DELAY_INIT = 5000000,
  parameter int DELAY_STEP = 500000,
  parameter int DELAY_MIN  = 500000
) (
  input  logic              clk,
  input  logic              reset,
  sprite_scroller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WRAP = 2'd2;

  localparam logic [8:0]  XS    = 9'(X_START);
  localparam logic [23:0] INIT  = 24'(DELAY_INIT);
  localparam logic [23:0] STEP  = 24'(DELAY_STEP);
  localparam logic [23:0] FLOOR = 24'(DELAY_MIN);

  logic [1:0]  state, state_nxt;
  logic [23:0] cnt, cur, cur_nxt;
  logic [8:0]  xoff;
  logic [3:0]  lvl, lvl_nxt;
  logic        wp, run_q;

  // Period and level after a wrap; compare in 25 bits so cur-STEP can never underflow.
`ifdef SPRITE_SCROLLER_RAMP_EN
  localparam logic [24:0] DEC_LIMIT = 25'(DELAY_MIN) + 25'(DELAY_STEP);
  always_comb begin
    cur_nxt = FLOOR;
    if ({1'b0, cur} >= DEC_LIMIT)
      cur_nxt = cur - STEP;
    lvl_nxt = (lvl == 4'd15) ? lvl : lvl + 4'd1;
  end
`else
  always_comb begin
    cur_nxt = INIT;
    lvl_nxt = 4'd0;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = RUN;
      RUN: begin
        if (!bus.enable)
          state_nxt = IDLE;
        else if (!bus.hit && !bus.pause && cnt == 24'd0 && xoff == 9'd0)
          state_nxt = WRAP;
      end
      WRAP:    state_nxt = bus.enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      xoff  <= XS;
      cnt   <= INIT;
      cur   <= INIT;
      lvl   <= 4'd0;
      wp    <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt != IDLE);
      wp    <= (state == RUN) && (state_nxt == WRAP);
      case (state)
        IDLE: begin
          xoff <= XS;
          cnt  <= cur;
        end
        RUN: begin
          if (!bus.enable) begin
            cur  <= INIT;
            cnt  <= INIT;
            lvl  <= 4'd0;
            xoff <= XS;
          end else if (bus.hit) begin
            xoff <= XS;
            cnt  <= cur;
          end else if (!bus.pause) begin
            if (cnt == 24'd0) begin
              cnt <= cur;
              if (xoff != 9'd0)
                xoff <= xoff - 9'd1;
            end else begin
              cnt <= cnt - 24'd1;
            end
          end
        end
        WRAP: begin
          xoff <= XS;
          cur  <= cur_nxt;
          cnt  <= cur_nxt;
          lvl  <= lvl_nxt;
        end
        default: xoff <= XS;
      endcase
    end
  end

  assign bus.xoffset    = xoff;
  assign bus.yoffset    = 8'(Y_POS);
  assign bus.wrap_pulse = wp;
  assign bus.level      = lvl;
  assign bus.running    = run_q;

endmodule

// File: tb/tb_sprite_scroller.sv
// Directed + randomized bench for sprite_scroller against a step-timing reference model.
module tb_sprite_scroller;
  localparam int XS = 3, YP = 120, DI = 4, DS = 1, DM = 2;
`ifdef SPRITE_SCROLLER_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic reset;
  sprite_scroller_if bus ();

  sprite_scroller #(.X_START(XS), .Y_POS(YP), .DELAY_INIT(DI),
                    .DELAY_STEP(DS), .DELAY_MIN(DM))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0=idle 1=run 2=wrap; m_wait = run cycles left until the next step.
  int m_mode, m_x, m_wait, m_cur, m_level;
  bit m_wp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit pa, input bit hi);
    int mode_n;
    mode_n = m_mode;
    m_wp = 1'b0;
    if (r) begin
      mode_n = 0; m_x = XS; m_cur = DI; m_level = 0; m_wait = DI + 1;
    end else if (m_mode == 0) begin
      m_x = XS; m_wait = m_cur + 1;
      if (en) mode_n = 1;
    end else if (m_mode == 1) begin
      if (!en) begin
        mode_n = 0; m_cur = DI; m_level = 0; m_x = XS;
      end else if (hi) begin
        m_x = XS; m_wait = m_cur + 1;
      end else if (!pa) begin
        m_wait--;
        if (m_wait == 0) begin
          m_wait = m_cur + 1;
          if (m_x > 0) m_x--;
          else begin mode_n = 2; m_wp = 1'b1; end
        end
      end
    end else begin
      m_x = XS;
      if (RAMP) begin
        m_cur = (m_cur - DS < DM) ? DM : m_cur - DS;
        m_level = (m_level >= 15) ? 15 : m_level + 1;
      end
      m_wait = m_cur + 1;
      mode_n = en ? 1 : 0;
    end
    m_mode = mode_n;
  endtask

  task automatic cycle(input bit r, input bit en, input bit pa, input bit hi);
    reset = r; bus.enable = en; bus.pause = pa; bus.hit = hi;
    model_step(r, en, pa, hi);
    @(posedge clk);
    #1;
    chk("xoffset", bus.xoffset, m_x);
    chk("yoffset", bus.yoffset, YP);
    chk("wrap_pulse", bus.wrap_pulse, m_wp);
    chk("level", bus.level, m_level);
    chk("running", bus.running, (m_mode != 0));
  endtask

  task automatic wait_x(input int target, output int n);
    n = 0;
    do begin cycle(0, 1, 0, 0); n++; end while (m_x != target && n < BOUND);
    chk("wait_x_bound", (n < BOUND), 1);
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin cycle(0, 1, 0, 0); n++; end while (!m_wp && n < BOUND);
    chk("wait_wrap_bound", (n < BOUND), 1);
  endtask

  initial begin
    int n, saved, guard;
    bit r, en, pa, hi;
    reset = 1'b1; bus.enable = 1'b0; bus.pause = 1'b0; bus.hit = 1'b0;
    m_mode = 0; m_x = XS; m_cur = DI; m_level = 0; m_wait = DI + 1; m_wp = 1'b0;
    #2;

    // Reset state and first wrap with exact step period.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("reset_x", bus.xoffset, XS);
    chk("reset_running", bus.running, 0);
    wait_x(2, n);
    wait_x(1, n);
    chk("period_init_a", n, 5);
    wait_x(0, n);
    chk("period_init_b", n, 5);
    wait_wrap(n);
    chk("wrap_after_x0", n, 5);
    wait_x(2, n);
    wait_x(1, n);
    chk("period_after_wrap1", n, RAMP ? 4 : 5);
    chk("level_after_wrap1", bus.level, RAMP ? 1 : 0);

    // Further wraps: cur floors at DELAY_MIN, level keeps counting.
    for (int k = 2; k <= 4; k++) begin
      wait_wrap(n);
      cycle(0, 1, 0, 0);
      chk("level_wrapk", bus.level, RAMP ? k : 0);
      wait_x(2, n);
      wait_x(1, n);
      chk("period_wrapk", n, RAMP ? ((k == 2) ? 3 : 3) : 5);
    end

    // Pause mid-run holds position for 20 cycles.
    cycle(0, 1, 0, 0);
    saved = m_x;
    for (int i = 0; i < 20; i++) cycle(0, 1, 1, 0);
    chk("pause_hold", bus.xoffset, saved);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

    // Hit at x=1, then hit coinciding with the wrap-due step at x=0.
    guard = 0;
    while (!(m_mode == 1 && m_x == 1) && guard < BOUND) begin cycle(0, 1, 0, 0); guard++; end
    chk("hit1_bound", (guard < BOUND), 1);
    saved = m_level;
    cycle(0, 1, 0, 1);
    chk("hit1_x", bus.xoffset, XS);
    chk("hit1_level", bus.level, saved);
    guard = 0;
    while (!(m_mode == 1 && m_x == 0 && m_wait == 1) && guard < BOUND) begin cycle(0, 1, 0, 0); guard++; end
    chk("hit0_bound", (guard < BOUND), 1);
    cycle(0, 1, 0, 1);
    chk("hit0_x", bus.xoffset, XS);
    chk("hit0_wp", bus.wrap_pulse, 0);
    cycle(0, 1, 0, 0);
    chk("hit0_wp_next", bus.wrap_pulse, 0);
    chk("hit0_level", bus.level, saved);

    // Reset during the WRAP cycle.
    wait_wrap(n);
    cycle(1, 1, 0, 0);
    chk("rst_wrap_level", bus.level, 0);
    chk("rst_wrap_wp", bus.wrap_pulse, 0);
    chk("rst_wrap_x", bus.xoffset, XS);
    chk("rst_wrap_running", bus.running, 0);

    // Disable mid-run returns to idle and clears level.
    for (int i = 0; i < 40; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("disable_running", bus.running, 0);
    chk("disable_level", bus.level, 0);

    // Randomized controls.
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 79) != 0);
      pa = ($urandom_range(0, 9) == 0);
      hi = ($urandom_range(0, 39) == 0);
      cycle(r, en, pa, hi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
